// File: rtl/oit_arb_pkg.sv
// oit_arb_pkg: state encoding for the round-robin arbiter.
package oit_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/oit_pkg.sv
// oit: shared library package with small elaboration-time helpers.
//   max(a, b) : larger of two ints
//   bits(n)   : bits needed to index n items (never less than 1)
package oit;

   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int bits(input int n);
      return max(1, $clog2(n));
   endfunction

endpackage

// File: rtl/oit_rr_pick.sv
// oit_rr_pick: combinational rotating-priority picker.
// Returns the first set bit of eligible at or after ptr, wrapping modulo N_REQ.
// Ports:
//   eligible [N_REQ] in  : candidate vector
//   ptr      [IDX_W] in  : highest-priority index this round
//   winner   [IDX_W] out : chosen index (0 when none)
//   valid            out : any candidate present
module oit_rr_pick #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = oit::bits(N_REQ)
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   logic [IDX_W-1:0] sel;

   // Scan from the far end toward ptr so the last hit (closest to ptr) wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      sel    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sel = IDX_W'((int'(ptr) + k) % N_REQ);
         if (eligible[sel]) begin
            winner = sel;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/oit_rr_arbiter.sv
// oit_rr_arbiter: round-robin owner arbiter for a single-ported resource.
// A requester keeps req high for its whole transaction; one owner at a time,
// with exactly one idle (GAP) cycle between owners. All outputs registered.
// Optional hold timeout: define OIT_ARB_TIMEOUT_EN. An owner still requesting
// after MAX_HOLD grant cycles is revoked and locked out until its req drops.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req   [N_REQ]     : per-requester level request
//   grant [N_REQ]     : one-hot grant, zero when free
//   grant_idx [IDX_W] : current owner, holds last owner while idle
//   busy              : |grant
//   timeout_pulse     : one cycle, coincident with the revoked grant falling
module oit_rr_arbiter
   import oit_arb_pkg::*;
#(
   parameter  int N_REQ    = 4,
   parameter  int MAX_HOLD = 256,
   localparam int IDX_W    = oit::bits(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             busy,
   output logic             timeout_pulse
);

   if (N_REQ < 1 || MAX_HOLD < 1) begin : g_bad_param
      $error("oit_rr_arbiter: N_REQ and MAX_HOLD must be >= 1");
   end

   arb_state_t       state, state_n;
   logic [N_REQ-1:0] grant_n;
   logic [IDX_W-1:0] idx_n;
   logic [IDX_W-1:0] ptr, ptr_n;
   logic [N_REQ-1:0] eligible;
   logic [IDX_W-1:0] win;
   logic             win_vld;
   logic             timeout;

   oit_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .eligible (eligible),
      .ptr      (ptr),
      .winner   (win),
      .valid    (win_vld)
   );

`ifdef OIT_ARB_TIMEOUT_EN
   localparam int CNT_W = oit::bits(MAX_HOLD + 1);

   logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
   logic [N_REQ-1:0] lockout, lockout_n;

   assign eligible = req & ~lockout;

   // hold_cnt is (grant cycles so far - 1); the edge that would make it
   // MAX_HOLD ends the MAX_HOLD-th grant cycle. A release on that same edge
   // wins over the revoke.
   assign timeout = (state == GRANT) && req[grant_idx] &&
                    (hold_cnt == CNT_W'(MAX_HOLD - 1));

   // Cleared in IDLE/GAP, so every entry into GRANT starts from zero.
   assign hold_cnt_n = (state == GRANT) ? hold_cnt + 1'b1 : '0;

   // A lockout bit persists only while its req stays high.
   always_comb begin
      lockout_n = lockout & req;
      if (timeout) lockout_n[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt      <= '0;
         lockout       <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         hold_cnt      <= hold_cnt_n;
         lockout       <= lockout_n;
         timeout_pulse <= timeout;
      end
   end
`else
   assign eligible      = req;
   assign timeout       = 1'b0;
   assign timeout_pulse = 1'b0;
`endif

   always_comb begin
      state_n = state;
      grant_n = grant;
      idx_n   = grant_idx;
      ptr_n   = ptr;
      case (state)
         IDLE, GAP: begin
            if (win_vld) begin
               state_n      = GRANT;
               grant_n      = '0;
               grant_n[win] = 1'b1;
               idx_n        = win;
               ptr_n        = IDX_W'((int'(win) + 1) % N_REQ);
            end else begin
               state_n = IDLE;
               grant_n = '0;
            end
         end
         GRANT: begin
            // Other req lines are ignored while an owner holds the resource.
            if (!req[grant_idx] || timeout) begin
               state_n = GAP;
               grant_n = '0;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         grant_idx <= '0;
         busy      <= 1'b0;
         ptr       <= '0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         grant_idx <= idx_n;
         busy      <= |grant_n;
         ptr       <= ptr_n;
      end
   end

endmodule
